nco_update_ctrl: RTL and testbench

NCO_UPDATE_CTRL -- requirements
Module: nco_update_ctrl

---
 rtl/nco_update_pkg.sv | 26 ++
 rtl/nco_rr_arb2.sv | 33 +++
 rtl/nco_update_ctrl.sv | 136 +++++++++++++
 tb/tb_nco_update_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_update_pkg.sv
// Shared types and constants for the NCO update controller.
// States, host mask bit positions, waveform codes and default widths.
package nco_update_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_WRAP,
        COMMIT
    } state_t;

    localparam int MASK_EN   = 0;
    localparam int MASK_WAVE = 1;
    localparam int MASK_FREQ = 2;
    localparam int MASK_DUTY = 3;

    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_SQUARE = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SAW    = 2'b11;

    localparam int DEF_FREQ_W  = 64;
    localparam int DEF_DUTY_W  = 16;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/nco_rr_arb2.sv
// Two-way round-robin arbiter: req[0] host, req[1] sweep.
// Last-grant register resets to sweep so the host wins the first tie.
module nco_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_sweep;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_sweep ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sweep <= 1'b1;
        end else if (|grant) begin
            last_sweep <= grant[1];
        end
    end

endmodule

// File: rtl/nco_update_ctrl.sv
// Glitch-free NCO parameter update controller (host + sweep sources).
// Optional WAIT_WRAP watchdog: define NCO_UPDATE_TIMEOUT_EN.
module nco_update_ctrl
    import nco_update_pkg::*;
#(
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              h_req,
    input  logic [3:0]        h_mask,
    input  logic              h_enable,
    input  logic [1:0]        h_wave,
    input  logic [FREQ_W-1:0] h_freq,
    input  logic [DUTY_W-1:0] h_duty,
    output logic              h_ack,
    input  logic              s_req,
    input  logic [FREQ_W-1:0] s_freq,
    output logic              s_ack,
    input  logic              phase_wrap,
    output logic              enable,
    output logic [1:0]        wave,
    output logic [FREQ_W-1:0] frequency,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              commit,
    output logic              busy,
    output logic              timeout_err
);

    state_t            state;
    logic [1:0]        grant;
    logic              gnt_sweep;
    logic              sh_en;
    logic [1:0]        sh_wave;
    logic [FREQ_W-1:0] sh_freq;
    logic [DUTY_W-1:0] sh_duty;

`ifdef NCO_UPDATE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             terr;
    assign timeout_err = terr;
`else
    // No watchdog built; the flag is constant low.
    assign timeout_err = (TIMEOUT < 0);
`endif

    nco_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({s_req, h_req}),
        .en      (state == IDLE),
        .grant   (grant)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt_sweep  <= 1'b0;
            enable     <= 1'b0;
            wave       <= WAVE_SINE;
            frequency  <= '0;
            duty_cycle <= '0;
            commit     <= 1'b0;
            h_ack      <= 1'b0;
            s_ack      <= 1'b0;
            sh_en      <= 1'b0;
            sh_wave    <= WAVE_SINE;
            sh_freq    <= '0;
            sh_duty    <= '0;
`ifdef NCO_UPDATE_TIMEOUT_EN
            wait_cnt   <= '0;
            terr       <= 1'b0;
`endif
        end else begin
            commit <= 1'b0;
            h_ack  <= 1'b0;
            s_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        gnt_sweep <= grant[1];
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Unselected fields carry the applied value forward.
                    if (gnt_sweep) begin
                        sh_en   <= enable;
                        sh_wave <= wave;
                        sh_freq <= s_freq;
                        sh_duty <= duty_cycle;
                    end else begin
                        sh_en   <= h_mask[MASK_EN]   ? h_enable : enable;
                        sh_wave <= h_mask[MASK_WAVE] ? h_wave   : wave;
                        sh_freq <= h_mask[MASK_FREQ] ? h_freq   : frequency;
                        sh_duty <= h_mask[MASK_DUTY] ? h_duty   : duty_cycle;
                    end
`ifdef NCO_UPDATE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= enable ? WAIT_WRAP : COMMIT;
                end
                WAIT_WRAP: begin
                    if (phase_wrap) begin
                        state <= COMMIT;
                    end
`ifdef NCO_UPDATE_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= COMMIT;
                        terr  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                COMMIT: begin
                    enable     <= sh_en;
                    wave       <= sh_wave;
                    frequency  <= sh_freq;
                    duty_cycle <= sh_duty;
                    commit     <= 1'b1;
                    h_ack      <= ~gnt_sweep;
                    s_ack      <= gnt_sweep;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_update_ctrl.sv
// Directed, table-driven bench for nco_update_ctrl.
// Timeout cases run only when NCO_UPDATE_TIMEOUT_EN is defined.
module tb_nco_update_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        h_req;
    logic [3:0]  h_mask;
    logic        h_enable;
    logic [1:0]  h_wave;
    logic [63:0] h_freq;
    logic [15:0] h_duty;
    logic        h_ack;
    logic        s_req;
    logic [63:0] s_freq;
    logic        s_ack;
    logic        phase_wrap;
    logic        enable;
    logic [1:0]  wave;
    logic [63:0] frequency;
    logic [15:0] duty_cycle;
    logic        commit;
    logic        busy;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    nco_update_ctrl #(
        .FREQ_W  (64),
        .DUTY_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .h_req       (h_req),
        .h_mask      (h_mask),
        .h_enable    (h_enable),
        .h_wave      (h_wave),
        .h_freq      (h_freq),
        .h_duty      (h_duty),
        .h_ack       (h_ack),
        .s_req       (s_req),
        .s_freq      (s_freq),
        .s_ack       (s_ack),
        .phase_wrap  (phase_wrap),
        .enable      (enable),
        .wave        (wave),
        .frequency   (frequency),
        .duty_cycle  (duty_cycle),
        .commit      (commit),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic        en;
        logic [1:0]  wv;
        logic [63:0] fq;
        logic [15:0] dt;
        int          lat;
        logic        x_en;
        logic [1:0]  x_wv;
        logic [63:0] x_fq;
        logic [15:0] x_dt;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Host transaction with phase_wrap held high; returns ack latency.
    task automatic host_txn(input logic [3:0] m, input logic e,
                            input logic [1:0] w, input logic [63:0] f,
                            input logic [15:0] d, output int lat);
        h_mask = m; h_enable = e; h_wave = w; h_freq = f; h_duty = d;
        h_req = 1'b1;
        phase_wrap = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (h_ack) begin
                lat = c;
                break;
            end
        end
        h_req = 1'b0;
        phase_wrap = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int cyc[4];
        logic sq[4];
        int acks;

        reset_n = 1'b0;
        h_req = 0; h_mask = 0; h_enable = 0; h_wave = 0;
        h_freq = 0; h_duty = 0; s_req = 0; s_freq = 0;
        phase_wrap = 0;

        vt[0] = '{4'b0000, 1'b0, 2'b11, 64'hFFFF, 16'h0001, 4,
                  1'b1, 2'b10, 64'h200, 16'hBEEF};
        vt[1] = '{4'b0010, 1'b0, 2'b01, 64'h1, 16'h1, 4,
                  1'b1, 2'b01, 64'h200, 16'hBEEF};
        vt[2] = '{4'b1100, 1'b0, 2'b00, 64'hABCD_0000_1234_5678,
                  16'h0001, 4,
                  1'b1, 2'b01, 64'hABCD_0000_1234_5678, 16'h0001};
        vt[3] = '{4'b1111, 1'b0, 2'b11, 64'h0, 16'hFFFF, 4,
                  1'b0, 2'b11, 64'h0, 16'hFFFF};
        vt[4] = '{4'b0001, 1'b1, 2'b00, 64'h5, 16'h5, 3,
                  1'b1, 2'b11, 64'h0, 16'hFFFF};
        vt[5] = '{4'b0100, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF,
                  16'h0, 4,
                  1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF};

        // Reset values
        tick();
        tick();
        chk("rst_enable", enable, 0);
        chk("rst_wave", wave, 0);
        chk("rst_freq", frequency, 0);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_ctl", {commit, h_ack, s_ack, busy, timeout_err}, 0);
        reset_n = 1'b1;

        // Tie: host first, then alternating, acks 3 cycles apart
        h_mask = 4'b0100; h_freq = 64'h33; s_freq = 64'h44;
        h_req = 1'b1; s_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            tick();
            if (h_ack || s_ack) begin
                chk("ack_excl", h_ack & s_ack, 0);
                sq[n] = s_ack;
                cyc[n] = c;
                n++;
                if (n == 4) begin
                    h_req = 1'b0;
                    s_req = 1'b0;
                end
            end
        end
        chk("rr_count", n, 4);
        for (int i = 0; i < 4 && i < n; i++) begin
            chk($sformatf("rr_order%0d", i), sq[i], (i % 2));
            chk($sformatf("rr_cycle%0d", i), cyc[i], 3 * (i + 1));
        end
        chk("rr_freq", frequency, 64'h44);
        tick();

        // Enable 0 -> 1 with frequency, 3-cycle latency
        h_mask = 4'b0101; h_enable = 1'b1; h_freq = 64'h10;
        h_wave = 2'b11; h_duty = 16'h1234; h_req = 1'b1;
        tick();
        chk("a_busy", busy, 1);
        tick();
        chk("a_hold", {h_ack, commit, enable}, 0);
        tick();
        h_req = 1'b0;
        chk("a_ack", {h_ack, s_ack, commit}, 3'b101);
        chk("a_enable", enable, 1);
        chk("a_freq", frequency, 64'h10);
        chk("a_wave", wave, 0);
        chk("a_duty", duty_cycle, 0);
        tick();
        chk("a_pulse", {h_ack, commit}, 0);

        // Sweep waits for phase_wrap raised 5 cycles after grant
        s_freq = 64'h200; s_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("b_wait%0d", k), {s_ack, commit}, 0);
            chk($sformatf("b_freq%0d", k), frequency, 64'h10);
            if (k == 5) phase_wrap = 1'b1;
            if (k == 6) phase_wrap = 1'b0;
        end
        tick();
        s_req = 1'b0;
        chk("b_ack", {h_ack, s_ack, commit}, 3'b011);
        chk("b_freq", frequency, 64'h200);

        // Wrap on first WAIT_WRAP cycle: 4-cycle latency
        tick();
        h_mask = 4'b0010; h_wave = 2'b10; h_req = 1'b1;
        tick();
        tick();
        phase_wrap = 1'b1;
        tick();
        phase_wrap = 1'b0;
        chk("c_early", h_ack, 0);
        tick();
        h_req = 1'b0;
        chk("c_ack", {h_ack, commit}, 2'b11);
        chk("c_wave", wave, 2'b10);

        // Host drops request during WAIT_WRAP
        tick();
        h_mask = 4'b1000; h_duty = 16'hBEEF; h_req = 1'b1;
        tick();
        tick();
        h_req = 1'b0;
        h_duty = 16'h0;
        tick();
        tick();
        phase_wrap = 1'b1;
        acks = 0;
        for (int c = 1; c <= 10 && acks == 0; c++) begin
            tick();
            phase_wrap = 1'b0;
            if (h_ack) acks++;
        end
        chk("d_ack", acks, 1);
        chk("d_duty", duty_cycle, 16'hBEEF);
        tick();

        // Table: masked host updates
        for (int i = 0; i < 6; i++) begin
            host_txn(vt[i].mask, vt[i].en, vt[i].wv, vt[i].fq,
                     vt[i].dt, lat);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_en", i), enable, vt[i].x_en);
            chk($sformatf("v%0d_wave", i), wave, vt[i].x_wv);
            chk($sformatf("v%0d_freq", i), frequency, vt[i].x_fq);
            chk($sformatf("v%0d_duty", i), duty_cycle, vt[i].x_dt);
            tick();
        end

        // Reset during WAIT_WRAP
        h_mask = 4'b0110; h_freq = 64'h77; h_wave = 2'b01;
        h_req = 1'b1;
        tick();
        tick();
        chk("e_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("e_out", {enable, wave, frequency, duty_cycle}, 0);
        chk("e_ctl", {commit, h_ack, s_ack, busy, timeout_err}, 0);
        h_req = 1'b0;
        tick();
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (h_ack || s_ack || commit) acks++;
        end
        chk("e_noack", acks, 0);
        chk("e_idle", {busy, frequency}, 0);

`ifdef NCO_UPDATE_TIMEOUT_EN
        // Forced commit after 8 wait cycles
        host_txn(4'b0001, 1'b1, 2'b00, 64'h0, 16'h0, lat);
        chk("f_en", enable, 1);
        tick();
        h_mask = 4'b0100; h_freq = 64'h99; h_req = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        chk("f_pre", {h_ack, timeout_err}, 2'b01);
        tick();
        h_req = 1'b0;
        chk("f_ack", h_ack, 1);
        chk("f_freq", frequency, 64'h99);
        for (int c = 0; c < 4; c++) tick();
        chk("f_sticky", timeout_err, 1);
        do_reset();
        #1;
        chk("f_clear", timeout_err, 0);

        // Wrap coincides with expiry: normal commit
        host_txn(4'b0001, 1'b1, 2'b00, 64'h0, 16'h0, lat);
        tick();
        h_mask = 4'b0100; h_freq = 64'h55; h_req = 1'b1;
        for (int c = 1; c <= 9; c++) tick();
        phase_wrap = 1'b1;
        tick();
        phase_wrap = 1'b0;
        tick();
        h_req = 1'b0;
        chk("g_ack", h_ack, 1);
        chk("g_freq", frequency, 64'h55);
        chk("g_err", timeout_err, 0);
        tick();
`else
        do_reset();
        tick();
        chk("noto_err", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
